i2c_master_write: RTL and testbench



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_quarter_tick.sv | 25 ++
 rtl/i2c_master_write.sv | 140 ++++++++++++++
 tb/tb_i2c_master_write.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C write master.
//   state_t          : transaction FSM states
//   I2C_ADDR_W       : 7-bit target address width
//   I2C_WRITE        : R/W bit value sent after the address
//   QUARTERS_PER_BIT : SCL quarter-periods per bit/ACK slot
package i2c_pkg;
  localparam int   I2C_ADDR_W       = 7;
  localparam logic I2C_WRITE        = 1'b0;
  localparam int   QUARTERS_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider.
//   clk, reset : system clock, synchronous active-high reset
//   en         : count while high; counter forced to 0 while low
//   tick       : one-cycle strobe on the last clk of each quarter
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !en)  cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/i2c_master_write.sv
// Single-byte I2C write master: START, address+W, ACK, data, ACK, STOP.
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_addr, cmd_data  : 7-bit target address, data byte (MSB first)
//   busy                : accept through done
//   done, nack          : one-cycle completion pulse and its result
//   sda_in              : synchronised bus SDA level
//   sda_oe, scl_oe      : open-drain pull-low enables (registered)
module i2c_master_write
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic [7:0]            cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  scl_oe
);
  localparam logic [1:0] LAST_Q = 2'(QUARTERS_PER_BIT - 1);

  state_t      state_q, state_n;
  logic [1:0]  qtr_q, qtr_n;
  logic [2:0]  bit_q, bit_n;
  // Bit on the wire is sh_q[8]; a trailing 1 is shifted in so that after
  // eight shifts the ACK slot sees a released SDA without special casing.
  logic [8:0]  sh_q, sh_n;
  logic [7:0]  data_q, data_n;
  logic        nack_q, nack_n;
  logic        tick;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (!(state_q == ST_IDLE || state_q == ST_DONE)),
    .tick  (tick)
  );

  // Line drive for a given state/quarter: {scl_oe, sda_oe}.
  function automatic logic [1:0] line_drive(state_t st, logic [1:0] q, logic b);
    case (st)
      ST_START:                 return {1'b0, q == 2'd1};
      ST_ADDR, ST_DATA:         return {~q[1], ~b};
      ST_ADDR_ACK, ST_DATA_ACK: return {~q[1], 1'b0};
      ST_STOP:                  return {q == 2'd0, ~q[1]};
      default:                  return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_n = state_q;
    qtr_n   = qtr_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    data_n  = data_q;
    nack_n  = nack_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_n = ST_START;
        sh_n    = {cmd_addr, I2C_WRITE, 1'b1};
        data_n  = cmd_data;
        nack_n  = 1'b0;
        qtr_n   = '0;
        bit_n   = '0;
      end
      ST_START: if (tick) begin
        if (qtr_q == 2'd1) begin
          state_n = ST_ADDR;
          qtr_n   = '0;
        end else qtr_n = qtr_q + 2'd1;
      end
      ST_ADDR, ST_DATA: if (tick) begin
        if (qtr_q == LAST_Q) begin
          qtr_n = '0;
          sh_n  = {sh_q[7:0], 1'b1};
          if (bit_q == 3'd7) begin
            bit_n   = '0;
            state_n = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
          end else bit_n = bit_q + 3'd1;
        end else qtr_n = qtr_q + 2'd1;
      end
      ST_ADDR_ACK, ST_DATA_ACK: if (tick) begin
        // ACK is sampled at the end of the first SCL-high quarter.
        if (qtr_q == 2'd2) nack_n = nack_q | sda_in;
        if (qtr_q == LAST_Q) begin
          qtr_n = '0;
          if (state_q == ST_ADDR_ACK && !nack_q) begin
            state_n = ST_DATA;
            sh_n    = {data_q, 1'b1};
          end else state_n = ST_STOP;
        end else qtr_n = qtr_q + 2'd1;
      end
      ST_STOP: if (tick) begin
        if (qtr_q == LAST_Q) begin
          state_n = ST_DONE;
          qtr_n   = '0;
        end else qtr_n = qtr_q + 2'd1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are derived from next-state values so they are registered
  // and line in exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      qtr_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      state_q          <= state_n;
      qtr_q            <= qtr_n;
      bit_q            <= bit_n;
      sh_q             <= sh_n;
      data_q           <= data_n;
      nack_q           <= nack_n;
      {scl_oe, sda_oe} <= line_drive(state_n, qtr_n, sh_n[8]);
      cmd_ready        <= (state_n == ST_IDLE);
      busy             <= (state_n != ST_IDLE);
      done             <= (state_n == ST_DONE);
      nack             <= (state_n == ST_DONE) && nack_n;
    end
  end
endmodule

// File: tb/tb_i2c_master_write.sv
// Directed bench for i2c_master_write with an open-drain bus model and an
// ACKing target that decodes bytes and START/STOP conditions.
module tb_i2c_master_write;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       busy, done, nack;
  logic       sda_in, sda_oe, scl_oe;

  int n_assert = 0;
  int n_fail   = 0;

  // Target model state
  logic       ack_addr = 1'b1;
  logic       ack_data = 1'b1;
  logic       ack_drive = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       scl_l, sda_l;
  logic [7:0] mon_cur = '0;
  logic [7:0] mon_bytes [64];
  int         mon_starts = 0, mon_stops = 0, mon_nbytes = 0;
  int         mon_bitcnt = 0, mon_byte_idx = 0;

  always #5 clk = ~clk;

  assign sda_in = ~(sda_oe | ack_drive);

  i2c_master_write #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .scl_oe    (scl_oe)
  );

  always @(negedge clk) begin
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | ack_drive);
    if (scl_l && prev_scl && prev_sda && !sda_l) begin
      mon_starts++;
      mon_bitcnt   = 0;
      mon_byte_idx = 0;
    end else if (scl_l && prev_scl && !prev_sda && sda_l) begin
      mon_stops++;
    end else if (scl_l && !prev_scl) begin
      if (mon_bitcnt < 8) begin
        mon_cur = {mon_cur[6:0], sda_l};
        mon_bitcnt++;
        if (mon_bitcnt == 8) begin
          mon_bytes[mon_nbytes & 63] = mon_cur;
          mon_nbytes++;
        end
      end else mon_bitcnt++;
    end else if (!scl_l && prev_scl) begin
      if (mon_bitcnt == 8)
        ack_drive = (mon_byte_idx == 0) ? ack_addr : ack_data;
      else if (mon_bitcnt == 9) begin
        ack_drive  = 1'b0;
        mon_bitcnt = 0;
        mon_byte_idx++;
      end
    end
    prev_scl = scl_l;
    prev_sda = ~(sda_oe | ack_drive);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one clk; returns at accept edge + 1.
  task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic hold);
    @(negedge clk);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = hold;
  endtask

  // Clocks from the current point until done, bounded.
  task automatic wait_done(output int lat, output logic nk);
    lat = 0;
    nk  = 1'bx;
    while (lat < 1000) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) begin
        nk = nack;
        break;
      end
    end
  endtask

  initial begin
    int   lat, s0, p0, b0;
    logic nk;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Full write, both bytes ACKed
    s0 = mon_starts; p0 = mon_stops; b0 = mon_nbytes;
    #1 check("ok_ready_pre", cmd_ready, 1);
    issue(7'h50, 8'hA5, 1'b0);
    check("ok_busy", busy, 1);
    check("ok_ready_busy", cmd_ready, 0);
    wait_done(lat, nk);
    check("ok_latency", lat, 312);
    check("ok_nack", nk, 0);
    check("ok_nbytes", mon_nbytes - b0, 2);
    check("ok_addr_byte", mon_bytes[b0 & 63], 8'hA0);
    check("ok_data_byte", mon_bytes[(b0 + 1) & 63], 8'hA5);
    check("ok_starts", mon_starts - s0, 1);
    check("ok_stops", mon_stops - p0, 1);
    @(posedge clk); #1;
    check("ok_done_pulse", done, 0);
    check("ok_ready_after", cmd_ready, 1);

    // No device: address NACK, data phase skipped
    ack_addr = 1'b0;
    s0 = mon_starts; p0 = mon_stops; b0 = mon_nbytes;
    issue(7'h2A, 8'h3C, 1'b0);
    wait_done(lat, nk);
    check("nodev_latency", lat, 168);
    check("nodev_nack", nk, 1);
    check("nodev_nbytes", mon_nbytes - b0, 1);
    check("nodev_addr_byte", mon_bytes[b0 & 63], 8'h54);
    check("nodev_stops", mon_stops - p0, 1);

    // Address ACKed, data NACKed
    ack_addr = 1'b1;
    ack_data = 1'b0;
    b0 = mon_nbytes;
    repeat (2) @(posedge clk);
    issue(7'h0F, 8'h81, 1'b0);
    wait_done(lat, nk);
    check("dnack_latency", lat, 312);
    check("dnack_nack", nk, 1);
    check("dnack_data_byte", mon_bytes[(b0 + 1) & 63], 8'h81);
    ack_data = 1'b1;

    // Reset during the third address bit
    repeat (2) @(posedge clk);
    issue(7'h50, 8'hA5, 1'b0);
    repeat (42) @(posedge clk);
    #1;
    check("abort_bitcnt", mon_bitcnt, 2);
    check("abort_scl_pre", scl_oe, 1);
    p0 = mon_stops;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_sda_oe", sda_oe, 0);
    check("abort_scl_oe", scl_oe, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_stop", mon_stops - p0, 0);
    check("abort_idle_scl", scl_oe, 0);

    // Back-to-back with cmd_valid held
    s0 = mon_starts; b0 = mon_nbytes;
    issue(7'h50, 8'hA5, 1'b1);
    wait_done(lat, nk);
    check("b2b_lat1", lat, 312);
    @(posedge clk); #1;
    check("b2b_idle_ready", cmd_ready, 1);
    check("b2b_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("b2b_accept2", busy, 1);
    check("b2b_start_q0", {scl_oe, sda_oe}, 2'b00);
    cmd_data  = 8'h3C;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_start_q1", {scl_oe, sda_oe}, 2'b01);
    wait_done(lat, nk);
    check("b2b_lat2", lat + 4, 312);
    check("b2b_starts", mon_starts - s0, 2);
    check("b2b_data2", mon_bytes[(b0 + 3) & 63], 8'hA5);

    // cmd_valid pulsed mid-transaction is ignored
    repeat (2) @(posedge clk);
    s0 = mon_starts; b0 = mon_nbytes;
    issue(7'h3C, 8'h5A, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    cmd_addr  = 7'h11;
    cmd_data  = 8'h22;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(lat, nk);
    check("pulse_latency", lat, 211);
    check("pulse_nack", nk, 0);
    repeat (20) @(posedge clk);
    #1;
    check("pulse_starts", mon_starts - s0, 1);
    check("pulse_nbytes", mon_nbytes - b0, 2);
    check("pulse_addr", mon_bytes[b0 & 63], 8'h78);
    check("pulse_data", mon_bytes[(b0 + 1) & 63], 8'h5A);
    check("pulse_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
